// File: rtl/uart_tx_fifo.sv
// Buffered transmit front-end: circular FIFO plus a launcher that hands one entry
// at a time to a UART transmitter and waits for its frame-complete level.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_done,
  output logic [$clog2(DEPTH):0] count,
  output logic                  empty,
  output logic                  full,
  output logic                  busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wp;
  logic [AW-1:0]         r_rp;
  logic [AW:0]           r_count;
  logic [GW-1:0]         r_gap_cnt;
  logic [GW-1:0]         w_gap_cnt_next;
  logic                  r_tx_done_q;
  logic                  r_tx_start;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_done_rise;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == (AW+1)'(DEPTH));
  assign w_done_rise = tx_done && !r_tx_done_q;
  // Reset gating keeps the source from believing a write landed while flops are held.
  assign wr_ready    = !w_full && !arstn;
  assign w_push      = wr_valid && wr_ready;

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;
  assign busy     = (r_state != S_IDLE);

  always_comb begin
    w_state_next   = r_state;
    w_gap_cnt_next = r_gap_cnt;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_SEND;
        end
      end
      S_SEND: w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_done_rise) begin
          w_gap_cnt_next = GAP_LOAD;
          w_state_next   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) w_state_next = S_IDLE;
        else                 w_gap_cnt_next = r_gap_cnt - GW'(1);
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arstn) begin
    if (arstn) begin
      r_state     <= S_IDLE;
      r_gap_cnt   <= '0;
      r_tx_done_q <= 1'b0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_gap_cnt   <= w_gap_cnt_next;
      r_tx_done_q <= tx_done;
      r_tx_start  <= w_pop;
      if (w_pop) begin
        r_tx_data <= r_mem[r_rp];
        r_rp      <= r_rp + AW'(1);
      end
      if (w_push) r_wp <= r_wp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes feed a scoreboard that a combined
// monitor / transmitter responder drains on every tx_start pulse.
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int GAP   = 5;

  logic          clk = 1'b0;
  logic          arstn = 1'b1;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          tx_done = 1'b0;
  logic          wr_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic [4:0]    count;
  logic          empty;
  logic          full;
  logic          busy;

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .arstn(arstn), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .count(count), .empty(empty), .full(full), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests   = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int frame_len = 6;
  int n_starts  = 0;
  int last_r    = -1;
  int rsp_cnt   = 0;
  int rsp_hold  = 0;
  int starts_before = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Must be entered at a falling edge; returns at the falling edge after acceptance
  // with wr_valid still asserted.
  task automatic push(input logic [DW-1:0] b);
    int   t;
    logic acc;
    t        = 0;
    wr_valid = 1'b1;
    wr_data  = b;
    forever begin
      acc = wr_ready;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(b);
        break;
      end
      t++;
      if (t > 3000) begin
        check("push_timeout", 1, 0);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input int lim);
    int t;
    t = 0;
    while (!(empty && !busy) && t < lim) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", (t < lim), 1);
  endtask

  // Monitor plus transmitter model: each launch is a frame of frame_len cycles,
  // then tx_done is held high for two cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (arstn) begin
        rsp_cnt  = 0;
        rsp_hold = 0;
        tx_done  = 1'b0;
        last_r   = -1;
        continue;
      end
      if (tx_start) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          exp_b = exp_q.pop_front();
          check("tx_data", tx_data, exp_b);
        end
        if (last_r >= 0) check("gap_edges", cyc + 1 - last_r, GAP + 2);
        $display("[TB] launch %0d data=0x%02h edge=%0d", n_starts, tx_data, cyc + 1);
        last_r  = -1;
        rsp_cnt = frame_len;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          tx_done  = 1'b1;
          rsp_hold = 2;
          last_r   = (exp_q.size() != 0) ? cyc + 1 : -1;
        end
      end else if (rsp_hold > 0) begin
        rsp_hold--;
        if (rsp_hold == 0) tx_done = 1'b0;
      end
      check("count_model", count, exp_q.size());
      check("empty_model", empty, (exp_q.size() == 0));
      check("full_model", full, (exp_q.size() == DEPTH));
      check("wr_ready_model", wr_ready, (exp_q.size() != DEPTH));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while held
    repeat (50) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    arstn = 1'b0;
    @(negedge clk);
    check("wr_ready_release", wr_ready, 1);

    // Single byte: launch pulse visible two edges after the write edge
    frame_len = 6;
    push(8'hC9);
    wr_valid = 1'b0;
    check("single_start_early", tx_start, 0);
    check("single_count", count, 1);
    check("single_busy_early", busy, 0);
    @(negedge clk);
    check("single_start", tx_start, 1);
    check("single_data", tx_data, 8'hC9);
    check("single_busy", busy, 1);
    @(negedge clk);
    check("single_start_pulse", tx_start, 0);
    wait_idle(200);
    check("single_starts", n_starts, 1);

    // Push on the pop edge leaves count unchanged
    frame_len = 40;
    push(8'hF0);
    check("pp_count0", count, 1);
    push(8'hF1);
    check("pp_count1", count, 1);
    push(8'hF2);
    check("pp_count2", count, 2);
    push(8'hF3);
    check("pp_count3", count, 3);
    wr_valid = 1'b0;
    wait_idle(1000);
    check("pp_starts", n_starts, 5);

    // Burst to full, then a held overfill write
    frame_len = 60;
    push(8'h00);
    for (int i = 1; i <= 16; i++) push(DW'(i));
    check("burst_count", count, 16);
    check("burst_full", full, 1);
    check("burst_wr_ready", wr_ready, 0);
    push(8'hAA);
    wr_valid = 1'b0;
    check("overfill_count", count, 16);
    frame_len = 6;
    wait_idle(3000);
    check("burst_starts", n_starts, 23);
    check("burst_end_count", count, 0);
    check("burst_end_empty", empty, 1);

    // Pointer wrap with mixed data
    frame_len = 3;
    for (int i = 0; i < 40; i++) push(DW'((i * 37 + 11) & 255));
    wr_valid = 1'b0;
    wait_idle(3000);
    check("wrap_starts", n_starts, 63);

    // Reset during WAIT with four entries queued
    frame_len = 40;
    for (int i = 0; i < 5; i++) push(DW'(8'h11 + i));
    wr_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_count", count, 4);
    check("pre_rst_busy", busy, 1);
    @(posedge clk);
    #2;
    arstn = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_ready", wr_ready, 0);
    repeat (3) @(negedge clk);
    arstn = 1'b0;
    starts_before = n_starts;
    repeat (30) @(negedge clk);
    check("no_spurious_start", n_starts, starts_before);
    check("post_rst_busy", busy, 0);
    frame_len = 6;
    push(8'h5A);
    wr_valid = 1'b0;
    wait_idle(300);
    check("post_rst_starts", n_starts, starts_before + 1);
    check("post_rst_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

- Buffered transmit front-end that sits directly upstream of `uart_duplex`.
- Accepts bytes from the system side over a valid/ready write port and stores them in a circular FIFO.
- A launcher FSM pops one entry at a time, drives `tx_data` with a one-cycle `tx_start` pulse, and waits for the transmitter's `tx_done` before starting the next frame.
- An optional inter-frame idle gap is inserted after each frame.

## Interface
- `DATA_WIDTH`, 8: width of each FIFO entry and of `tx_data`. Must match the transmitter.
- `DEPTH`, 16: number of FIFO entries. Power of two, ≥ 2.
- `GAP_CYCLES`, 0: idle clk cycles inserted after each `tx_done` before the next `tx_start`. 0 disables the gap.
- `clk`  in  1  system clock.
- `arstn`  in  1  reset, asynchronous, active-high.
- `wr_valid`  in  1  write request.
- `wr_data`  in  DATA_WIDTH  byte to enqueue.
- `wr_ready`  out  1  FIFO can accept a write. Equals `!full`; forced 0 while `arstn` is high.
- `tx_start`  out  1  single-cycle launch pulse to the transmitter.
- `tx_data`  out  DATA_WIDTH  byte being transmitted. Held stable until the next launch.
- `tx_done`  in  1  frame-complete indication from the transmitter, treated as a level.
- `count`  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- `empty`  out  1  asserted when `count == 0`.
- `full`  out  1  asserted when `count == DEPTH`.
- `busy`  out  1  high whenever FSM state ≠ IDLE.

## Operation
- **FIFO storage**
  - Registered array, write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `count` is a separate register.
- **Push:** `wr_valid && wr_ready` at a rising edge. Stores `wr_data` at `wp`, then increments `wp`.
- **Pop:** issued only by the FSM on the IDLE→SEND transition. Copies `mem[rp]` to `tx_data`, then increments `rp`.
- **Push and pop on the same edge:** `count` unchanged, both pointers advance.
- **Full:** `wr_ready` is 0, so no push is accepted even if a pop occurs on the same edge. A write asserted on that edge must be held by the source.
- **Tx_done edge detection:** `tx_done_q` registers `tx_done`. `done_rise = tx_done && !tx_done_q`.
- **FSM states**
  - IDLE: if `!empty`, pop, set `tx_start` = 1, go to SEND.
  - SEND: `tx_start` = 0, go to WAIT. A `done_rise` seen in SEND is ignored.
  - WAIT: on `done_rise`, go to GAP if `GAP_CYCLES > 0`, otherwise to IDLE. Load `gap_cnt` = `GAP_CYCLES`-1.
  - GAP: decrement `gap_cnt`; at 0, go to IDLE.
- **Outputs:** `tx_start` is registered and is high only on the cycle immediately after the IDLE→SEND edge.
- **Reset (asynchronous assert)**
  - `wp`, `rp`, `count`, `gap_cnt`, `tx_done_q` = 0; `tx_data` = 0; `tx_start` = 0; state = IDLE.
  - `empty` = 1, `full` = 0, `busy` = 0, `wr_ready` = 0 during reset and 1 after release.
  - FIFO contents are discarded. Memory contents need no reset.
- **Reset mid-frame:** all queued data is lost and `tx_start` drops immediately. The transmitter shares `arstn`, so no partial-frame recovery is needed.

## Timing
- **Push to launch latency:** push accepted at edge k with FIFO empty and FSM in IDLE gives `count` = 1 after edge k, `tx_start` high for the cycle after edge k+1, and `tx_data` valid from edge k+1 on.
- **Back-to-back frames:** next `tx_start` follows at edge (r+1+GAP_CYCLES)+1, where r is the edge on which `done_rise` is sampled in WAIT.
- **Status outputs:** `count`, `empty` and `full` update on the edge of the push/pop. `wr_ready` is combinational from `full` and `arstn`.
- **Single launch per frame:** exactly one `tx_start` pulse per popped entry. Entries go out in FIFO order.

## Test plan
- **Single byte:** reset 50 cycles, write 0xC9 once → `tx_start` 1 cycle high two edges after the write. `tx_data` = 0xC9. Loopback RX returns 0xC9. `busy` returns to 0 after `tx_done`.
- **Burst, order preserved:** write 0x01..0x10 (16 bytes, DEPTH=16) back-to-back → `full` = 1 and `wr_ready` = 0 after the 16th write. Exactly 16 `tx_start` pulses. RX sequence is 0x01..0x10 in order. Ends with `count` = 0 and `empty` = 1.
- **Overfill hold:** with FIFO full, hold `wr_valid` with 0xAA → no push until the first pop frees a slot. 0xAA is transmitted 17th. `count` never exceeds 16.
- **Gap timing:** `GAP_CYCLES` = 5, two queued bytes → exactly 7 edges from the `done_rise` sample edge to the second `tx_start` pulse.
- **Simultaneous push/pop and wrap:** push on the IDLE→SEND edge with `count` = 3 → `count` stays 3. After 40 pushes/pops, pointers have wrapped and data integrity still holds.
- **Reset mid-operation:** assert `arstn` during WAIT with 4 entries queued → `tx_start` = 0, `count` = 0, `empty` = 1, `busy` = 0 at once. After release, no spurious `tx_start` until a new write.
